proc_ctrl_fsm: RTL and testbench
================================

// Module: proc_ctrl_fsm
// PURPOSE
//   Parametrised control unit for the simple processor datapath. Owns its state register.
//   Accepts one instruction per start/done handshake and sequences register-bus enables
//   (r_in/r_out), A/G register strobes and ALU op selects over multi-cycle steps.
//   Supports NUM_REGS registers, latches operands, flags illegal instructions.
// PARAMETERS
//   NUM_REGS  8  number of general registers; r_in/r_out width
//   SEL_W     3  register-select width; must satisfy 2**SEL_W >= NUM_REGS
//   FUNC_W    4  opcode width; must be >= 4
// PORTS
//   clk          in   1         clock, all state updates on rising edge
//   reset        in   1         synchronous, active-high reset
//   start        in   1         instruction valid; sampled only in IDLE
//   func         in   FUNC_W    opcode, latched with start
//   rx           in   SEL_W     destination / first operand, latched with start
//   ry           in   SEL_W     source / second operand, latched with start
//   busy         out  1         1 in every state except IDLE
//   done         out  1         1-cycle pulse in DONE
//   illegal      out  1         1-cycle pulse in DONE when instruction rejected
//   data_out     out  1         drive external data onto bus (LOAD)
//   r_in         out  NUM_REGS  one-hot register write enables
//   r_out        out  NUM_REGS  one-hot register bus-drive enables
//   add_sub      out  1         1 = subtract
//   a_in, g_in, g_out  out 1 each  A latch, G latch, G drives bus
//   math_enables out  7         [6]xor [5]add [4]sub [3]and [2]or [1]div [0]mod
// BEHAVIOUR
//   - Reset: state=IDLE, latched func/rx/ry=0; all outputs 0. Reset mid-instruction
//     aborts: next cycle IDLE, no done pulse, all outputs 0.
//   - Opcodes: 1 LOAD, 2 MOVE, 3 ADD, 4 SUB, 5 XOR, 6 OR, 7 AND, 8 DIV, 9 MOD; else illegal.
//   - Outputs are decoded from state register + latched fields only (no input paths).
//   - States: IDLE, LOAD, MOVE, T1, T2, T3, DONE.
//     IDLE: start=1 -> latch func/rx/ry; go LOAD / MOVE / T1 / DONE(illegal) per opcode.
//       start=0 -> stay. start in any other state ignored (no queueing).
//     LOAD: data_out=1, r_in=onehot(rx) -> DONE.
//     MOVE: r_out=onehot(ry), r_in=onehot(rx) -> DONE. rx==ry legal (same bit in both).
//     T1: r_out=onehot(rx), a_in=1 -> T2.
//     T2: r_out=onehot(ry), g_in=1 -> T3.
//     T3: g_out=1, r_in=onehot(rx) -> DONE.
//     T1..T3: math_enables = op one-hot; add_sub=1 only for SUB.
//     DONE: done=1, illegal=1 if rejected -> IDLE. No enables asserted.
//   - Latency, start sampled at edge 0: LOAD/MOVE done in cycle 2;
//     ALU ops done in cycle 4; illegal done in cycle 1. Next start accepted in cycle after DONE.
//   - Illegal: opcode not 1..9, or rx/ry >= NUM_REGS (ry checked only for MOVE/ALU).
//     Nothing written.
//   - At most one bit set in r_in and in r_out at any cycle; 0 when unused.
// CONFIGURATION
//   MULTICYCLE_ALU_EN defined: adds input alu_ready (1 bit). T2 holds (all T2 outputs stable)
//     until alu_ready=1, then -> T3. Applies to all ALU ops; alu_ready ignored elsewhere.
//     reset during the hold -> IDLE.
//   Not defined: no alu_ready port; T2 always lasts exactly one cycle.
// TESTING
//   reset 3 cycles -> busy=0, done=0, r_in=r_out=0, math_enables=0.
//   start, func=1, rx=5 -> cycle1 data_out=1, r_in=8'h20; cycle2 done=1; cycle3 busy=0.
//   start, func=4, rx=2, ry=6 -> T1 r_out=04, a_in=1; T2 r_out=40, g_in=1;
//     T3 g_out=1, r_in=04; add_sub=1, math_enables=7'b0010000 in T1..T3; done in cycle 4.
//   start, func=4'hF -> cycle1 done=1 and illegal=1; no enable ever asserted.
//   ADD in flight, start pulsed in T2, reset asserted in T3 -> next cycle IDLE, all 0, no done.
//   MULTICYCLE_ALU_EN: DIV, alu_ready=0 for 3 cycles -> T2 outputs held, T3 after alu_ready=1.

Source files
------------

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: multi-step register-bus sequencer for the simple processor datapath; MULTICYCLE_ALU_EN adds alu_ready to stretch T2
module proc_ctrl_fsm #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int FUNC_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [FUNC_W-1:0]   func,
  input  logic [SEL_W-1:0]    rx,
  input  logic [SEL_W-1:0]    ry,
`ifdef MULTICYCLE_ALU_EN
  input  logic                alu_ready,
`endif
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                data_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                add_sub,
  output logic                a_in,
  output logic                g_in,
  output logic                g_out,
  output logic [6:0]          math_enables
);
  typedef enum logic [2:0] {IDLE, LOAD, MOVE, T1, T2, T3, DONE} state_t;
  state_t state_q, state_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [SEL_W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic ill_q, ill_d;
  logic op_load, op_move, op_alu, rx_ok, ry_ok, legal, alu_st;
  logic [NUM_REGS-1:0] rx_hot, ry_hot;
  logic [6:0] op_hot;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      func_q  <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      ill_q   <= ill_d;
    end
  end
  always_comb begin
    op_load = func == FUNC_W'(1);
    op_move = func == FUNC_W'(2);
    op_alu  = func >= FUNC_W'(3) && func <= FUNC_W'(9);
    rx_ok   = 32'(rx) < NUM_REGS;
    ry_ok   = 32'(ry) < NUM_REGS;
    legal   = (op_load && rx_ok) || ((op_move || op_alu) && rx_ok && ry_ok);
    func_d  = func_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    ill_d   = ill_q;
    state_d = state_q;
    if (state_q == IDLE && start) begin
      func_d  = func;
      rx_d    = rx;
      ry_d    = ry;
      ill_d   = !legal;
      state_d = !legal ? DONE : op_load ? LOAD : op_move ? MOVE : T1;
    end
    if (state_q == LOAD || state_q == MOVE || state_q == T3) state_d = DONE;
    if (state_q == T1) state_d = T2;
`ifdef MULTICYCLE_ALU_EN
    if (state_q == T2) state_d = alu_ready ? T3 : T2;
`else
    if (state_q == T2) state_d = T3;
`endif
    if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    rx_hot = NUM_REGS'(1) << rx_q;
    ry_hot = NUM_REGS'(1) << ry_q;
    alu_st = state_q == T1 || state_q == T2 || state_q == T3;
    op_hot = func_q == FUNC_W'(3) ? 7'b0100000 :
             func_q == FUNC_W'(4) ? 7'b0010000 :
             func_q == FUNC_W'(5) ? 7'b1000000 :
             func_q == FUNC_W'(6) ? 7'b0000100 :
             func_q == FUNC_W'(7) ? 7'b0001000 :
             func_q == FUNC_W'(8) ? 7'b0000010 :
             func_q == FUNC_W'(9) ? 7'b0000001 : 7'b0000000;
    busy         = state_q != IDLE;
    done         = state_q == DONE;
    illegal      = state_q == DONE && ill_q;
    data_out     = state_q == LOAD;
    r_in         = (state_q == LOAD || state_q == MOVE || state_q == T3) ? rx_hot : '0;
    r_out        = (state_q == MOVE || state_q == T2) ? ry_hot : state_q == T1 ? rx_hot : '0;
    a_in         = state_q == T1;
    g_in         = state_q == T2;
    g_out        = state_q == T3;
    add_sub      = alu_st && func_q == FUNC_W'(4);
    math_enables = alu_st ? op_hot : 7'b0;
  end
endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm: directed and random instructions checked cycle by cycle against a per-instruction step-list model
module tb_proc_ctrl_fsm;
  typedef struct packed {
    logic busy, done, illegal, data_out;
    logic [7:0] r_in, r_out;
    logic add_sub, a_in, g_in, g_out;
    logic [6:0] me;
  } outs_t;
`ifdef MULTICYCLE_ALU_EN
  localparam bit MC = 1'b1;
  logic alu_ready;
`else
  localparam bit MC = 1'b0;
`endif
  logic clk = 1'b0, reset, start;
  logic [3:0] func;
  logic [2:0] rx, ry;
  logic busy, done, illegal, data_out, add_sub, a_in, g_in, g_out;
  logic [7:0] r_in, r_out;
  logic [6:0] math_enables;
  outs_t cur, obs;
  outs_t q[$];
  int n_chk = 0, n_err = 0;
  proc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .start(start), .func(func), .rx(rx), .ry(ry),
`ifdef MULTICYCLE_ALU_EN
    .alu_ready(alu_ready),
`endif
    .busy(busy), .done(done), .illegal(illegal), .data_out(data_out),
    .r_in(r_in), .r_out(r_out), .add_sub(add_sub), .a_in(a_in), .g_in(g_in),
    .g_out(g_out), .math_enables(math_enables)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic build(input logic [3:0] f, input logic [2:0] x, input logic [2:0] y);
    outs_t t, dn;
    logic [6:0] m;
    m = f == 3 ? 7'b0100000 : f == 4 ? 7'b0010000 : f == 5 ? 7'b1000000 :
        f == 6 ? 7'b0000100 : f == 7 ? 7'b0001000 : f == 8 ? 7'b0000010 :
        f == 9 ? 7'b0000001 : 7'b0;
    dn = '0; dn.busy = 1; dn.done = 1;
    t = '0; t.busy = 1;
    if (f == 1) begin
      t.data_out = 1; t.r_in = 8'd1 << x; q.push_back(t);
    end else if (f == 2) begin
      t.r_in = 8'd1 << x; t.r_out = 8'd1 << y; q.push_back(t);
    end else if (f >= 3 && f <= 9) begin
      t.me = m; t.add_sub = f == 4;
      t.r_out = 8'd1 << x; t.a_in = 1; q.push_back(t);
      t.a_in = 0; t.r_out = 8'd1 << y; t.g_in = 1; q.push_back(t);
      t.g_in = 0; t.r_out = 0; t.g_out = 1; t.r_in = 8'd1 << x; q.push_back(t);
    end else dn.illegal = 1;
    q.push_back(dn);
  endtask
  task automatic cyc(input string tag, input logic r, input logic s, input logic [3:0] f,
                     input logic [2:0] x, input logic [2:0] y, input logic ar);
    reset = r; start = s; func = f; rx = x; ry = y;
`ifdef MULTICYCLE_ALU_EN
    alu_ready = ar;
`endif
    @(posedge clk);
    if (r) begin
      q.delete(); cur = '0;
    end else if (!cur.busy) begin
      if (s) begin build(f, x, y); cur = q.pop_front(); end
    end else if (MC && cur.g_in && !ar) begin
    end else cur = q.size() > 0 ? q.pop_front() : '0;
    @(negedge clk);
    obs = '{busy, done, illegal, data_out, r_in, r_out, add_sub, a_in, g_in, g_out, math_enables};
    check(tag, obs, cur);
  endtask
  initial begin
    cur = '0;
    repeat (3) cyc("reset", 1, 0, 0, 0, 0, 1);
    cyc("load_t1", 0, 1, 1, 5, 0, 1);
    check("load_r_in", {23'b0, r_in}, 31'h20);
    cyc("load_done", 0, 0, 0, 0, 0, 1);
    cyc("load_idle", 0, 0, 0, 0, 0, 1);
    cyc("sub_t1", 0, 1, 4, 2, 6, 1);
    check("sub_r_out_t1", {23'b0, r_out}, 31'h04);
    cyc("sub_t2", 0, 0, 0, 0, 0, 1);
    check("sub_r_out_t2", {23'b0, r_out}, 31'h40);
    cyc("sub_t3", 0, 0, 0, 0, 0, 1);
    check("sub_me_t3", {24'b0, math_enables}, 31'b0010000);
    cyc("sub_done", 0, 0, 0, 0, 0, 1);
    cyc("sub_idle", 0, 0, 0, 0, 0, 1);
    cyc("ill_done", 0, 1, 4'hF, 3, 3, 1);
    check("ill_flag", {29'b0, done, illegal}, 31'b11);
    cyc("ill_idle", 0, 0, 0, 0, 0, 1);
    cyc("move_same", 0, 1, 2, 7, 7, 1);
    cyc("move_done", 0, 0, 0, 0, 0, 1);
    cyc("add_t1", 0, 1, 3, 1, 4, 1);
    cyc("add_t2", 0, 0, 0, 0, 0, 1);
    cyc("add_start_t2", 0, 1, 1, 6, 0, 1);
    cyc("add_reset_t3", 1, 0, 0, 0, 0, 1);
    check("abort_busy", {30'b0, busy, done}, 31'b0);
    cyc("after_abort", 0, 0, 0, 0, 0, 1);
`ifdef MULTICYCLE_ALU_EN
    cyc("div_t1", 0, 1, 8, 3, 5, 0);
    repeat (4) cyc("div_hold", 0, 0, 0, 0, 0, 0);
    cyc("div_t3", 0, 0, 0, 0, 0, 1);
    check("div_t3_g_out", {30'b0, g_out, g_in}, 31'b10);
    cyc("div_done", 0, 0, 0, 0, 0, 1);
    cyc("div_idle", 0, 0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 3000; i++)
      cyc("random", $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
          4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
